// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter: default-width data types,
// arbiter FSM states and arbitration modes.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } lc3b_arb_mode;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational next-grant picker: round-robin starting after last_grant,
// or fixed priority with port 0 highest.
module rr_grant_select
    import lc3b_types::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         request,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
    input  lc3b_arb_mode                 mode,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         valid
);

    localparam int GRANT_W = $clog2(NUM_PORTS);

    logic [GRANT_W-1:0] idx;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        if (mode == ARB_FIXED) begin
            // Scanning high-to-low lets the lowest requester overwrite last.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (request[GRANT_W'(i)]) begin
                    grant = GRANT_W'(i);
                    valid = 1'b1;
                end
            end
        end else begin
            // Farthest offset first, so the nearest port after last_grant wins.
            for (int k = NUM_PORTS; k >= 1; k--) begin
                idx = GRANT_W'((int'(last_grant) + k) % NUM_PORTS);
                if (request[idx]) begin
                    grant = idx;
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: grants one requester at a time, holds the
// latched request on the memory side until mem_resp, then pulses port_resp.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int           NUM_PORTS  = 2,
    parameter int           ADDR_WIDTH = 16,
    parameter int           DATA_WIDTH = 16,
    parameter lc3b_arb_mode ARB_MODE   = ARB_RR
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 port_read,
    input  logic [NUM_PORTS-1:0]                 port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      port_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  port_byte_enable,
    output logic [NUM_PORTS-1:0]                 port_resp,
    output logic [DATA_WIDTH-1:0]                port_rdata,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_WIDTH-1:0]                mem_address,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic [DATA_WIDTH/8-1:0]              mem_byte_enable,
    input  logic                                 mem_resp,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]         grant_id
);

    localparam int GRANT_W  = $clog2(NUM_PORTS);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    lc3b_arb_state        state;
    logic [GRANT_W-1:0]   last_grant;
    logic                 op_write_q;

    logic [GRANT_W-1:0]   sel_grant;
    logic                 sel_valid;
    logic                 sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]  sel_be;

    rr_grant_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_grant_select (
        .request    (port_read | port_write),
        .last_grant (last_grant),
        .mode       (ARB_MODE),
        .grant      (sel_grant),
        .valid      (sel_valid)
    );

    // A port raising read and write together is served as a write.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_grant == GRANT_W'(i)) begin
                sel_write = port_write[i];
                sel_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_be    = port_byte_enable[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= GRANT_W'(NUM_PORTS - 1);
            grant_id        <= '0;
            op_write_q      <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            port_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_id        <= sel_grant;
                        last_grant      <= sel_grant;
                        op_write_q      <= sel_write;
                        mem_address     <= sel_addr;
                        mem_wdata       <= sel_wdata;
                        mem_byte_enable <= sel_be;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        if (!op_write_q) begin
                            port_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes exist only in BUSY, so they drop on the edge that leaves it.
    assign mem_read  = (state == BUSY) && !op_write_q;
    assign mem_write = (state == BUSY) &&  op_write_q;

    always_comb begin
        port_resp = '0;
        if (state == DONE) begin
            port_resp[grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed round-robin sequences, random traffic
// against a transaction-level model, and a fixed-priority vector table.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Round-robin instance, two ports
    logic [1:0]  r_port_read, r_port_write, r_port_resp;
    logic [31:0] r_port_address, r_port_wdata;
    logic [3:0]  r_port_be;
    logic [15:0] r_port_rdata, r_mem_address, r_mem_wdata, r_mem_rdata;
    logic        r_mem_read, r_mem_write, r_mem_resp;
    logic [1:0]  r_mem_be;
    logic [0:0]  r_grant_id;

    // Fixed-priority instance, four ports
    logic [3:0]  f_port_read, f_port_write, f_port_resp;
    logic [63:0] f_port_address, f_port_wdata;
    logic [7:0]  f_port_be;
    logic [15:0] f_port_rdata, f_mem_address, f_mem_wdata, f_mem_rdata;
    logic        f_mem_read, f_mem_write, f_mem_resp;
    logic [1:0]  f_mem_be;
    logic [1:0]  f_grant_id;

    mem_arbiter dut_rr (
        .clk(clk), .reset(reset),
        .port_read(r_port_read), .port_write(r_port_write),
        .port_address(r_port_address), .port_wdata(r_port_wdata),
        .port_byte_enable(r_port_be), .port_resp(r_port_resp),
        .port_rdata(r_port_rdata), .mem_read(r_mem_read), .mem_write(r_mem_write),
        .mem_address(r_mem_address), .mem_wdata(r_mem_wdata),
        .mem_byte_enable(r_mem_be), .mem_resp(r_mem_resp),
        .mem_rdata(r_mem_rdata), .grant_id(r_grant_id)
    );

    mem_arbiter #(
        .NUM_PORTS(4), .ARB_MODE(lc3b_types::ARB_FIXED)
    ) dut_fx (
        .clk(clk), .reset(reset),
        .port_read(f_port_read), .port_write(f_port_write),
        .port_address(f_port_address), .port_wdata(f_port_wdata),
        .port_byte_enable(f_port_be), .port_resp(f_port_resp),
        .port_rdata(f_port_rdata), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
        .mem_byte_enable(f_mem_be), .mem_resp(f_mem_resp),
        .mem_rdata(f_mem_rdata), .grant_id(f_grant_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-port request state for the round-robin instance
    logic        req_rd[2], req_wr[2];
    logic [15:0] req_addr[2], req_wdata[2];
    logic [1:0]  req_be[2];

    task automatic drive_rr();
        r_port_read    = {req_rd[1], req_rd[0]};
        r_port_write   = {req_wr[1], req_wr[0]};
        r_port_address = {req_addr[1], req_addr[0]};
        r_port_wdata   = {req_wdata[1], req_wdata[0]};
        r_port_be      = {req_be[1], req_be[0]};
    endtask

    task automatic clear_rr();
        for (int p = 0; p < 2; p++) begin
            req_rd[p] = 1'b0; req_wr[p] = 1'b0;
            req_addr[p] = '0; req_wdata[p] = '0; req_be[p] = '0;
        end
        drive_rr();
    endtask

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        int         exp_port;
        logic       exp_write;
    } fx_vec_t;

    fx_vec_t fx_tab[8];

    // Transaction-level model state for random traffic
    int          m_phase;   // 0 waiting for a request, 1 memory access, 2 response
    int          m_cur, m_last, lat_cnt, win, op;
    logic        m_write;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_be;
    logic [15:0] fx_rdata;

    initial begin
        fx_tab[0] = '{4'b1010, 4'b0000, 1, 1'b0};
        fx_tab[1] = '{4'b1000, 4'b0000, 3, 1'b0};
        fx_tab[2] = '{4'b0000, 4'b0100, 2, 1'b1};
        fx_tab[3] = '{4'b1111, 4'b0000, 0, 1'b0};
        fx_tab[4] = '{4'b0001, 4'b0001, 0, 1'b1};
        fx_tab[5] = '{4'b1100, 4'b0010, 1, 1'b1};
        fx_tab[6] = '{4'b0110, 4'b1000, 1, 1'b0};
        fx_tab[7] = '{4'b0000, 4'b1001, 0, 1'b1};

        clear_rr();
        r_mem_resp = 1'b0; r_mem_rdata = '0;
        f_port_read = '0; f_port_write = '0; f_port_be = 8'b11_10_01_11;
        f_port_address = {16'h1030, 16'h1020, 16'h1010, 16'h1000};
        f_port_wdata   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        f_mem_resp = 1'b0; f_mem_rdata = '0;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("reset port_resp", r_port_resp, 0);
        check("reset mem_read", r_mem_read, 0);
        check("reset mem_write", r_mem_write, 0);
        check("reset port_rdata", r_port_rdata, 0);
        check("reset mem_address", r_mem_address, 0);
        check("reset mem_wdata", r_mem_wdata, 0);
        check("reset mem_be", r_mem_be, 0);
        check("reset grant_id", r_grant_id, 0);

        // Single read, memory answers one cycle after the strobe
        req_rd[0] = 1'b1; req_addr[0] = 16'h1234; drive_rr();
        tick();
        check("read strobe", r_mem_read, 1);
        check("read no write", r_mem_write, 0);
        check("read address", r_mem_address, 16'h1234);
        check("read grant", r_grant_id, 0);
        check("read no resp yet", r_port_resp, 0);
        tick();
        check("read strobe held", r_mem_read, 1);
        r_mem_resp = 1'b1; r_mem_rdata = 16'hBEEF;
        tick();
        check("read port_resp", r_port_resp, 2'b01);
        check("read strobe low in done", r_mem_read, 0);
        check("read rdata", r_port_rdata, 16'hBEEF);
        r_mem_resp = 1'b0; clear_rr();
        tick();
        check("read resp one cycle", r_port_resp, 0);

        // Read+write together on port 0 becomes a write
        req_rd[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 16'h0010;
        req_wdata[0] = 16'h1111; req_be[0] = 2'b11; drive_rr();
        tick();
        check("conflict mem_write", r_mem_write, 1);
        check("conflict mem_read", r_mem_read, 0);
        check("conflict address", r_mem_address, 16'h0010);
        r_mem_resp = 1'b1; r_mem_rdata = 16'hDEAD;
        tick();
        check("conflict port_resp", r_port_resp, 2'b01);
        check("conflict rdata kept", r_port_rdata, 16'hBEEF);
        r_mem_resp = 1'b0; clear_rr();
        tick();

        // Masked write from port 1; port inputs change during BUSY
        req_wr[1] = 1'b1; req_addr[1] = 16'h0040; req_wdata[1] = 16'hA5A5;
        req_be[1] = 2'b10; drive_rr();
        tick();
        check("mask mem_write", r_mem_write, 1);
        check("mask be", r_mem_be, 2'b10);
        check("mask wdata", r_mem_wdata, 16'hA5A5);
        check("mask grant", r_grant_id, 1);
        req_addr[1] = 16'hFFFF; req_wdata[1] = 16'h0000; req_be[1] = 2'b01;
        req_rd[0] = 1'b1; req_addr[0] = 16'h0002; drive_rr();
        tick();
        check("busy ignores addr", r_mem_address, 16'h0040);
        check("busy ignores wdata", r_mem_wdata, 16'hA5A5);
        check("busy ignores be", r_mem_be, 2'b10);
        r_mem_resp = 1'b1; r_mem_rdata = 16'h7777;
        tick();
        check("mask port_resp", r_port_resp, 2'b10);
        check("mask rdata kept", r_port_rdata, 16'hBEEF);
        req_wr[1] = 1'b0; drive_rr();
        tick();
        check("no regrant in done", r_mem_read, 0);
        check("idle no resp", r_port_resp, 0);
        r_mem_resp = 1'b0;
        tick();
        check("new grant port0", r_grant_id, 0);
        check("new grant strobe", r_mem_read, 1);
        check("new grant address", r_mem_address, 16'h0002);

        // Reset while BUSY with a same-cycle mem_resp
        r_mem_resp = 1'b1; r_mem_rdata = 16'h5555; reset = 1'b1;
        tick();
        check("abort port_resp", r_port_resp, 0);
        check("abort mem_read", r_mem_read, 0);
        check("abort mem_write", r_mem_write, 0);
        check("abort rdata", r_port_rdata, 0);
        reset = 1'b0; r_mem_resp = 1'b0; clear_rr();
        tick();
        check("abort idle resp", r_port_resp, 0);
        check("abort idle strobe", r_mem_read | r_mem_write, 0);

        // Both ports reading continuously: grants alternate from port 0
        req_rd[0] = 1'b1; req_addr[0] = 16'h0100;
        req_rd[1] = 1'b1; req_addr[1] = 16'h0200; drive_rr();
        r_mem_resp = 1'b1; r_mem_rdata = 16'h0BAD;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("rr grant", r_grant_id, t % 2);
            check("rr address", r_mem_address, (t % 2 == 0) ? 16'h0100 : 16'h0200);
            tick();
            check("rr port_resp", r_port_resp, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        r_mem_resp = 1'b0; clear_rr();
        tick();

        // Random traffic against the transaction-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_phase = 0; m_cur = 0; m_last = 1; m_rdata = '0; lat_cnt = 0;
        m_write = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            case (m_phase)
                0: begin
                    win = -1;
                    for (int k = 2; k >= 1; k--) begin
                        if (req_rd[(m_last + k) % 2] || req_wr[(m_last + k) % 2]) begin
                            win = (m_last + k) % 2;
                        end
                    end
                    if (win >= 0) begin
                        m_cur = win; m_last = win;
                        m_write = req_wr[win]; m_addr = req_addr[win];
                        m_wdata = req_wdata[win]; m_be = req_be[win];
                        lat_cnt = $urandom_range(0, 2);
                        m_phase = 1;
                    end
                end
                1: begin
                    if (r_mem_resp) begin
                        if (!m_write) m_rdata = r_mem_rdata;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase

            check("rnd mem_read", r_mem_read, (m_phase == 1) && !m_write);
            check("rnd mem_write", r_mem_write, (m_phase == 1) && m_write);
            if (m_phase == 1) begin
                check("rnd mem_address", r_mem_address, m_addr);
                check("rnd mem_wdata", r_mem_wdata, m_wdata);
                check("rnd mem_be", r_mem_be, m_be);
            end
            check("rnd grant_id", r_grant_id, m_cur);
            check("rnd port_resp", r_port_resp, (m_phase == 2) ? (32'd1 << m_cur) : 32'd0);
            check("rnd port_rdata", r_port_rdata, m_rdata);

            if (m_phase == 2) begin
                req_rd[m_cur] = 1'b0; req_wr[m_cur] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!req_rd[p] && !req_wr[p] && $urandom_range(0, 2) == 0) begin
                    op = $urandom_range(0, 3);
                    req_rd[p]    = (op != 2);
                    req_wr[p]    = (op >= 2);
                    req_addr[p]  = 16'($urandom);
                    req_wdata[p] = 16'($urandom);
                    req_be[p]    = 2'($urandom);
                end
            end
            if (m_phase == 1) begin
                if (lat_cnt == 0) begin
                    r_mem_resp = 1'b1;
                end else begin
                    r_mem_resp = 1'b0;
                    lat_cnt--;
                end
            end else begin
                r_mem_resp = 1'($urandom);
            end
            r_mem_rdata = 16'($urandom);
            drive_rr();
        end
        clear_rr(); r_mem_resp = 1'b0;

        // Fixed-priority vector table, each row one complete transaction
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fx_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            f_port_read = fx_tab[i].rd; f_port_write = fx_tab[i].wr;
            tick();
            check("fx grant", f_grant_id, fx_tab[i].exp_port);
            check("fx mem_write", f_mem_write, fx_tab[i].exp_write);
            check("fx mem_read", f_mem_read, !fx_tab[i].exp_write);
            check("fx address", f_mem_address, 32'h1000 + 32'(fx_tab[i].exp_port) * 32'h10);
            f_mem_resp = 1'b1; f_mem_rdata = 16'h4000 + 16'(i);
            tick();
            if (!fx_tab[i].exp_write) fx_rdata = 16'h4000 + 16'(i);
            check("fx port_resp", f_port_resp, 32'd1 << fx_tab[i].exp_port);
            check("fx rdata", f_port_rdata, fx_rdata);
            f_port_read = '0; f_port_write = '0; f_mem_resp = 1'b0;
            tick();
        end

        // Ports 1 and 3 request together: 1 first, then 3
        f_port_read = 4'b1010; f_mem_resp = 1'b1; f_mem_rdata = 16'h0101;
        tick();
        check("fx pair first", f_grant_id, 1);
        tick();
        check("fx pair resp1", f_port_resp, 4'b0010);
        f_port_read = 4'b1000; f_mem_rdata = 16'h0303;
        tick();
        check("fx pair idle", f_port_resp, 0);
        tick();
        check("fx pair second", f_grant_id, 3);
        check("fx pair address", f_mem_address, 16'h1030);
        tick();
        check("fx pair resp3", f_port_resp, 4'b1000);
        check("fx pair rdata", f_port_rdata, 16'h0303);
        f_port_read = '0; f_mem_resp = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2; number of requester ports, legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 16; address width in bits.
REQ-003 Parameter DATA_WIDTH, default 16; data width in bits, multiple of 8; byte-enable width BE_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter ARB_MODE, default ARB_RR; ARB_RR selects round-robin, ARB_FIXED selects fixed priority with port 0 highest.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 port_read  in  NUM_PORTS  per-port read request, held until that port's port_resp.
REQ-008 port_write  in  NUM_PORTS  per-port write request, held until that port's port_resp.
REQ-009 port_address  in  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-010 port_wdata  in  NUM_PORTS x DATA_WIDTH  per-port write data.
REQ-011 port_byte_enable  in  NUM_PORTS x BE_WIDTH  per-port write byte mask.
REQ-012 port_resp  out  NUM_PORTS  one-cycle completion pulse, one-hot or zero.
REQ-013 port_rdata  out  DATA_WIDTH  registered read data, valid when a port_resp bit is high.
REQ-014 mem_read, mem_write  out  1 each  downstream request strobes.
REQ-015 mem_address  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_byte_enable  out  BE_WIDTH  downstream request fields.
REQ-016 mem_resp  in  1; mem_rdata  in  DATA_WIDTH  downstream completion and read data.
REQ-017 grant_id  out  $clog2(NUM_PORTS)  index of the port currently or most recently granted.

Function
REQ-018 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-019 In IDLE with any port_read|port_write asserted, the block SHALL select one port, latch its address, wdata, byte_enable and operation into internal registers, set grant_id, and enter BUSY on the next edge.
REQ-020 In ARB_RR mode, the search SHALL start at (last_grant+1) mod NUM_PORTS and wrap; in ARB_FIXED mode, the lowest-index requester SHALL win.
REQ-021 If a port asserts port_read and port_write together, the block SHALL perform a write and ignore the read.
REQ-022 In BUSY, mem_* outputs SHALL be driven only from the latched registers; changes on port inputs SHALL have no effect.
REQ-023 In BUSY with mem_resp high, the block SHALL capture mem_rdata into port_rdata (reads only), deassert mem_read/mem_write on the next edge, and enter DONE.
REQ-024 In DONE, port_resp[grant_id] SHALL be high for exactly that one cycle, and mem_read/mem_write SHALL be low; the next state SHALL be IDLE unconditionally.
REQ-025 Minimum request-to-response latency SHALL be 3 cycles: request seen in IDLE, mem strobe in BUSY with same-cycle mem_resp, port_resp in DONE.
REQ-026 The returned request SHALL NOT be re-granted in DONE; a port still requesting in the following IDLE cycle SHALL be treated as a new request.
REQ-027 port_rdata SHALL hold its value until the next read completes; write completions SHALL NOT alter it.
REQ-028 mem_read and mem_write SHALL never be high together, and SHALL be low in IDLE and DONE.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, and port_resp, mem_read and mem_write SHALL be 0.
REQ-030 On reset, port_rdata, mem_address, mem_wdata, mem_byte_enable and grant_id SHALL be 0, and last_grant SHALL be NUM_PORTS-1, so port 0 wins first.
REQ-031 Reset asserted during BUSY SHALL abort the transaction with no port_resp; a mem_resp arriving in the same cycle SHALL be ignored.

Structure
REQ-032 Package lc3b_types SHALL gain the enum lc3b_arb_state {IDLE, BUSY, DONE} and the enum lc3b_arb_mode {ARB_RR, ARB_FIXED}; lc3b_word and lc3b_mem_wmask remain the default-width types.
REQ-033 Next-grant selection SHALL be one combinational sub-module, rr_grant_select (inputs: request vector, last_grant, mode; output: grant index, valid).

Verification
REQ-034 Single read: port0 reads 0x1234, memory returns 0xBEEF with mem_resp one cycle after mem_read -> mem_address=0x1234; port_resp=2'b01 one cycle later; port_rdata=0xBEEF.
REQ-035 Round-robin contention: NUM_PORTS=2, both ports read continuously -> grants alternate 0,1,0,1 over four transactions; grant_id never repeats back to back.
REQ-036 Fixed priority: ARB_FIXED, NUM_PORTS=4, ports 1 and 3 request -> port 1 served first, then port 3.
REQ-037 Write with mask: port1 writes 0xA5A5 to 0x0040 with byte_enable=2'b10 -> mem_write=1, mem_byte_enable=2'b10, mem_wdata=0xA5A5; port_resp=2'b10; port_rdata unchanged.
REQ-038 Read+write conflict: port0 asserts both to 0x0010 -> only mem_write is asserted.
REQ-039 Reset mid-transaction: reset during BUSY with mem_resp=1 in the same cycle -> no port_resp, FSM in IDLE, all strobes 0 on the next cycle.
